// File: rtl/sdram_writer.sv
// Avalon-MM burst write master: drains a dual-clock show-ahead pixel FIFO into the
// DDR3 frame buffer in fixed-length bursts, wrapping the address once per frame.
module sdram_writer_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                     aclr,
  input  logic                     wrclk,
  input  logic                     wrreq,
  input  logic [WIDTH-1:0]         data,
  output logic                     wrfull,
  input  logic                     rdclk,
  input  logic                     rdreq,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(DEPTH):0]   rdusedw
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wbin, wgray, wnext, rbin, rgray, rnext;
  logic [AW:0] rgray_s1, rgray_s2, wgray_s1, wgray_s2;
  logic        wr_ok, rd_ok;

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign wnext  = wbin + (AW+1)'(1);
  assign rnext  = rbin + (AW+1)'(1);
  assign wr_ok  = wrreq & ~wrfull;
  assign rd_ok  = rdreq & (rdusedw != '0);
  assign wrfull = (wbin - g2b(rgray_s2)) == (AW+1)'(DEPTH);
  assign rdusedw = g2b(wgray_s2) - rbin;
  // Show-ahead: the head word is visible on q without a read request.
  assign q = mem[rbin[AW-1:0]];

  always_ff @(posedge wrclk) if (wr_ok) mem[wbin[AW-1:0]] <= data;

  always_ff @(posedge wrclk or posedge aclr)
    if (aclr) begin
      wbin <= '0; wgray <= '0; rgray_s1 <= '0; rgray_s2 <= '0;
    end else begin
      rgray_s1 <= rgray;
      rgray_s2 <= rgray_s1;
      if (wr_ok) begin
        wbin  <= wnext;
        wgray <= wnext ^ (wnext >> 1);
      end
    end

  always_ff @(posedge rdclk or posedge aclr)
    if (aclr) begin
      rbin <= '0; rgray <= '0; wgray_s1 <= '0; wgray_s2 <= '0;
    end else begin
      wgray_s1 <= wgray;
      wgray_s2 <= wgray_s1;
      if (rd_ok) begin
        rbin  <= rnext;
        rgray <= rnext ^ (rnext >> 1);
      end
    end
endmodule

module sdram_writer #(
  parameter int          SDRAM_DATA_WIDTH = 64,
  parameter int          FIFO_DEPTH       = 256,
  parameter int          BURST_LEN        = 16,
  parameter logic [26:0] BASE_ADDR        = 27'h400_0000,
  parameter logic [31:0] FRAME_WORDS      = 32'hFD200
) (
  input  logic                          sdram_clk,
  input  logic                          rst,
  input  logic                          src_clk,
  input  logic                          enable_i,
  input  logic                          src_wr_i,
  input  logic [SDRAM_DATA_WIDTH-1:0]   src_data_i,
  output logic                          src_full_o,
  output logic                          frame_ready_o,
  output logic                          frame_done_o,
  output logic [26:0]                   sdram_address_o,
  output logic [7:0]                    sdram_burstcount_o,
  output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
  output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
  output logic                          sdram_write_o,
  input  logic                          sdram_waitrequest_i
);
  localparam int UW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [26:0]     burst_addr;
  logic [BW-1:0]   beat;
  logic [31:0]     frame_cnt;
  logic [UW-1:0]   rdusedw;
  logic            beat_ok, rdreq;

  assign beat_ok            = sdram_write_o & ~sdram_waitrequest_i;
  assign rdreq              = (state == BURST) & beat_ok;
  assign sdram_burstcount_o = 8'(BURST_LEN);
  assign sdram_byteenable_o = '1;

  sdram_writer_fifo #(.WIDTH(SDRAM_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .aclr(rst), .wrclk(src_clk), .wrreq(src_wr_i), .data(src_data_i), .wrfull(src_full_o),
    .rdclk(sdram_clk), .rdreq(rdreq), .q(sdram_writedata_o), .rdusedw(rdusedw)
  );

  always_ff @(posedge sdram_clk)
    if (rst) begin
      state           <= IDLE;
      sdram_write_o   <= 1'b0;
      sdram_address_o <= BASE_ADDR;
      burst_addr      <= BASE_ADDR;
      beat            <= '0;
      frame_cnt       <= '0;
      frame_done_o    <= 1'b0;
      frame_ready_o   <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        // A full burst must already be buffered, so write never drops mid-burst.
        IDLE: if (enable_i && rdusedw >= UW'(BURST_LEN)) begin
          sdram_address_o <= burst_addr;
          sdram_write_o   <= 1'b1;
          beat            <= '0;
          state           <= BURST;
        end
        BURST: if (beat_ok) begin
          beat <= beat + BW'(1);
          if (beat == BW'(BURST_LEN - 1)) begin
            sdram_write_o <= 1'b0;
            state         <= IDLE;
            if (frame_cnt + 32'(BURST_LEN) == FRAME_WORDS) begin
              burst_addr    <= BASE_ADDR;
              frame_cnt     <= '0;
              frame_done_o  <= 1'b1;
              frame_ready_o <= 1'b1;
            end else begin
              burst_addr <= burst_addr + 27'(BURST_LEN);
              frame_cnt  <= frame_cnt + 32'(BURST_LEN);
            end
          end
        end
      endcase
    end
endmodule

// File: tb/tb_sdram_writer.sv
// Bench for sdram_writer with a 64-word frame: a negedge monitor drives waitrequest and
// records accepted beats; scenario tasks compare them against a word/address model.
module tb_sdram_writer;
  localparam int          DW    = 64;
  localparam int          BL    = 16;
  localparam int          FRAME = 64;
  localparam logic [26:0] BASE  = 27'h400_0000;

  logic sdram_clk = 0, src_clk = 0, rst = 1, enable_i = 0, src_wr_i = 0;
  logic [DW-1:0] src_data_i = '0;
  logic src_full_o, frame_ready_o, frame_done_o, sdram_write_o, sdram_waitrequest_i = 0;
  logic [26:0] sdram_address_o;
  logic [7:0]  sdram_burstcount_o;
  logic [DW-1:0] sdram_writedata_o;
  logic [DW/8-1:0] sdram_byteenable_o;

  sdram_writer #(.SDRAM_DATA_WIDTH(DW), .FIFO_DEPTH(256), .BURST_LEN(BL),
                 .BASE_ADDR(BASE), .FRAME_WORDS(32'(FRAME))) dut (
    .sdram_clk(sdram_clk), .rst(rst), .src_clk(src_clk), .enable_i(enable_i),
    .src_wr_i(src_wr_i), .src_data_i(src_data_i), .src_full_o(src_full_o),
    .frame_ready_o(frame_ready_o), .frame_done_o(frame_done_o),
    .sdram_address_o(sdram_address_o), .sdram_burstcount_o(sdram_burstcount_o),
    .sdram_writedata_o(sdram_writedata_o), .sdram_byteenable_o(sdram_byteenable_o),
    .sdram_write_o(sdram_write_o), .sdram_waitrequest_i(sdram_waitrequest_i)
  );

  always #5 sdram_clk = ~sdram_clk;
  always #7 src_clk = ~src_clk;

  int checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_data[$];
  logic [26:0]   burst_addrs[$];
  int burst_cycles[$], done_beats[$];
  int stall_left[BL];
  int stalls_seen = 0, viol = 0;
  bit rand_stall = 0;

  // Frame buffer address of the burst carrying beat i (counted since reset).
  function automatic logic [26:0] exp_addr(input int i);
    return BASE + 27'(((i / BL) % (FRAME / BL)) * BL);
  endfunction

  task automatic monitor();
    logic in_burst = 0, prev_stall = 0, prev_done = 0, stall;
    logic [DW-1:0] prev_data = '0;
    logic [26:0] cur_addr = '0;
    int beat_idx = 0, cyc = 0;
    forever begin
      @(negedge sdram_clk);
      if (frame_done_o) begin
        done_beats.push_back(got_data.size());
        if (prev_done) viol++;
      end
      prev_done = frame_done_o;
      if (rst) begin
        in_burst = 0; beat_idx = 0; prev_stall = 0; sdram_waitrequest_i = 0;
      end else if (sdram_write_o) begin
        if (!in_burst) begin
          in_burst = 1; beat_idx = 0; cyc = 0; cur_addr = sdram_address_o;
          burst_addrs.push_back(cur_addr);
          if (sdram_burstcount_o !== 8'(BL) || sdram_byteenable_o !== '1) viol++;
        end else if (sdram_address_o !== cur_addr ||
                     (prev_stall && sdram_writedata_o !== prev_data)) viol++;
        cyc++;
        stall = 0;
        if (beat_idx < BL && stall_left[beat_idx] > 0) begin
          stall = 1; stall_left[beat_idx]--;
        end else if (rand_stall) stall = ($urandom_range(0, 3) == 0);
        sdram_waitrequest_i = stall;
        if (stall) stalls_seen++;
        else begin
          if (beat_idx >= BL) viol++; else got_data.push_back(sdram_writedata_o);
          beat_idx++;
        end
        prev_stall = stall; prev_data = sdram_writedata_o;
      end else begin
        if (in_burst) begin
          burst_cycles.push_back(cyc);
          if (beat_idx != BL) viol++;
        end
        in_burst = 0; prev_stall = 0; sdram_waitrequest_i = 0;
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); got_data.delete(); burst_addrs.delete();
    burst_cycles.delete(); done_beats.delete();
    stalls_seen = 0; viol = 0; rand_stall = 0;
    foreach (stall_left[i]) stall_left[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge sdram_clk); #1;
    rst = 1; enable_i = 0;
    repeat (3) @(negedge sdram_clk);
    #1; clear_model(); rst = 0;
    @(negedge sdram_clk); #1;
  endtask

  task automatic push_words(input int n, input bit rnd, input logic [DW-1:0] start);
    for (int i = 0; i < n; i++) begin
      @(negedge src_clk);
      src_data_i = rnd ? {$urandom, $urandom} : start + DW'(i);
      src_wr_i = !src_full_o;
      if (!src_full_o) exp_q.push_back(src_data_i);
    end
    @(negedge src_clk);
    src_wr_i = 0;
  endtask

  task automatic wait_beats(input int n, output bit ok);
    for (int c = 0; c < 4000 && got_data.size() < n; c++) @(negedge sdram_clk);
    repeat (3) @(negedge sdram_clk);
    #1; ok = got_data.size() >= n;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sdram_write_o !== 1'b0) begin errors++; $display("FAIL rst_write got %b exp 0", sdram_write_o); end
    checks++; if (sdram_address_o !== BASE) begin errors++; $display("FAIL rst_addr got %h exp %h", sdram_address_o, BASE); end
    checks++; if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", frame_ready_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frame_done_o); end
    checks++; if (sdram_burstcount_o !== 8'(BL)) begin errors++; $display("FAIL rst_burstcount got %0d exp %0d", sdram_burstcount_o, BL); end
    checks++; if (sdram_byteenable_o !== 8'hFF) begin errors++; $display("FAIL rst_byteenable got %h exp ff", sdram_byteenable_o); end
    checks++; if (src_full_o !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", src_full_o); end
  endtask

  task automatic test_single_burst();
    bit ok;
    do_reset(); enable_i = 1;
    push_words(BL, 0, '0);
    wait_beats(BL, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d beats exp %0d", got_data.size(), BL); end
    else for (int i = 0; i < BL; i++) begin
      checks++; if (got_data[i] !== DW'(i)) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", i, got_data[i], DW'(i)); end
    end
    checks++; if (burst_addrs.size() != 1 || burst_addrs[0] !== BASE) begin errors++; $display("FAIL single_addr got %0d bursts first %h exp 1 at %h", burst_addrs.size(), burst_addrs[0], BASE); end
    checks++; if (burst_cycles.size() != 1 || burst_cycles[0] != BL) begin errors++; $display("FAIL single_cycles got %0d exp %0d", burst_cycles[0], BL); end
    checks++; if (viol != 0) begin errors++; $display("FAIL single_protocol got %0d violations exp 0", viol); end
  endtask

  task automatic test_waitrequest();
    bit ok;
    do_reset();
    stall_left[0] = 1; stall_left[5] = 2; stall_left[15] = 1;
    enable_i = 1;
    push_words(BL, 1, '0);
    wait_beats(BL, ok);
    checks++; if (!ok || got_data.size() != BL) begin errors++; $display("FAIL stall_count got %0d beats exp %0d", got_data.size(), BL); end
    for (int i = 0; i < BL && i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL stall_data[%0d] got %h exp %h", i, got_data[i], exp_q[i]); end
    end
    checks++; if (stalls_seen != 4) begin errors++; $display("FAIL stall_seen got %0d exp 4", stalls_seen); end
    checks++; if (burst_cycles.size() != 1 || burst_cycles[0] != BL + 4) begin errors++; $display("FAIL stall_cycles got %0d exp %0d", burst_cycles[0], BL + 4); end
    checks++; if (viol != 0) begin errors++; $display("FAIL stall_protocol got %0d violations exp 0", viol); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset(); enable_i = 1;
    push_words(3 * BL, 1, '0);
    wait_beats(3 * BL, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d beats exp %0d", got_data.size(), 3 * BL); end
    else for (int i = 0; i < 3 * BL; i++) begin
      checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, got_data[i], exp_q[i]); end
    end
    checks++; if (burst_addrs.size() != 3) begin errors++; $display("FAIL b2b_bursts got %0d exp 3", burst_addrs.size()); end
    else for (int b = 0; b < 3; b++) begin
      checks++; if (burst_addrs[b] !== exp_addr(b * BL)) begin errors++; $display("FAIL b2b_addr[%0d] got %h exp %h", b, burst_addrs[b], exp_addr(b * BL)); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL b2b_protocol got %0d violations exp 0", viol); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    do_reset();
    push_words(3 * BL, 1, '0);
    repeat (5) @(negedge sdram_clk);
    #1; enable_i = 1;
    for (int c = 0; c < 200 && got_data.size() < 3; c++) @(negedge sdram_clk);
    #1; enable_i = 0;
    repeat (100) @(negedge sdram_clk);
    #1;
    checks++; if (got_data.size() != BL) begin errors++; $display("FAIL endrop_beats got %0d exp %0d", got_data.size(), BL); end
    checks++; if (burst_addrs.size() != 1) begin errors++; $display("FAIL endrop_bursts got %0d exp 1", burst_addrs.size()); end
    enable_i = 1;
    wait_beats(3 * BL, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_resume got %0d beats exp %0d", got_data.size(), 3 * BL); end
    else for (int i = 0; i < 3 * BL; i++) begin
      checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL endrop_data[%0d] got %h exp %h", i, got_data[i], exp_q[i]); end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL endrop_protocol got %0d violations exp 0", viol); end
  endtask

  task automatic test_random_stall();
    bit ok;
    do_reset(); rand_stall = 1; enable_i = 1;
    push_words(6 * BL, 1, '0);
    wait_beats(6 * BL, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout got %0d beats exp %0d", got_data.size(), 6 * BL); end
    else for (int i = 0; i < 6 * BL; i++) begin
      checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", i, got_data[i], exp_q[i]); end
    end
    for (int b = 0; b < burst_addrs.size(); b++) begin
      checks++; if (burst_addrs[b] !== exp_addr(b * BL)) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", b, burst_addrs[b], exp_addr(b * BL)); end
    end
    checks++; if (done_beats.size() != 1) begin errors++; $display("FAIL rnd_done got %0d pulses exp 1", done_beats.size()); end
    checks++; if (viol != 0) begin errors++; $display("FAIL rnd_protocol got %0d violations exp 0", viol); end
    rand_stall = 0;
  endtask

  task automatic test_frame_wrap();
    bit ok;
    do_reset(); enable_i = 1;
    push_words(FRAME + BL, 1, '0);
    wait_beats(FRAME + BL, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout got %0d beats exp %0d", got_data.size(), FRAME + BL); end
    else for (int i = 0; i < FRAME + BL; i++) begin
      checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL frame_data[%0d] got %h exp %h", i, got_data[i], exp_q[i]); end
    end
    checks++; if (burst_addrs.size() != 5 || burst_addrs[4] !== BASE) begin errors++; $display("FAIL frame_wrap_addr got %0d bursts last %h exp 5 at %h", burst_addrs.size(), burst_addrs[burst_addrs.size()-1], BASE); end
    checks++; if (done_beats.size() != 1 || done_beats[0] != FRAME) begin errors++; $display("FAIL frame_done got %0d pulses at beat %0d exp 1 at %0d", done_beats.size(), done_beats[0], FRAME); end
    repeat (50) @(negedge sdram_clk);
    #1;
    checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL frame_ready got %b exp 1", frame_ready_o); end
    checks++; if (viol != 0) begin errors++; $display("FAIL frame_protocol got %0d violations exp 0", viol); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int base_n = got_data.size();
    push_words(2 * BL, 1, '0);
    for (int c = 0; c < 400 && got_data.size() < base_n + 7; c++) @(negedge sdram_clk);
    #1; rst = 1;
    @(negedge sdram_clk); #1;
    checks++; if (sdram_write_o !== 1'b0) begin errors++; $display("FAIL midrst_write got %b exp 0", sdram_write_o); end
    checks++; if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", frame_ready_o); end
    repeat (2) @(negedge sdram_clk);
    #1; clear_model(); rst = 0;
    @(negedge sdram_clk); #1;
    checks++; if (sdram_address_o !== BASE) begin errors++; $display("FAIL midrst_addr got %h exp %h", sdram_address_o, BASE); end
    push_words(BL, 1, '0);
    wait_beats(BL, ok);
    checks++; if (!ok || got_data.size() != BL) begin errors++; $display("FAIL midrst_beats got %0d exp %0d", got_data.size(), BL); end
    for (int i = 0; i < BL && i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_data[%0d] got %h exp %h", i, got_data[i], exp_q[i]); end
    end
    checks++; if (burst_addrs.size() != 1 || burst_addrs[0] !== BASE) begin errors++; $display("FAIL midrst_burst_addr got %0d bursts exp 1 at %h", burst_addrs.size(), BASE); end
    checks++; if (frame_ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready_after got %b exp 0", frame_ready_o); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    foreach (stall_left[i]) stall_left[i] = 0;
    fork monitor(); join_none
    test_reset();
    test_single_burst();
    test_waitrequest();
    test_back_to_back();
    test_enable_drop();
    test_random_stall();
    test_frame_wrap();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
